lsq_mem_ctrl: RTL and testbench
===============================

LSQ_MEM_CTRL -- requirements
Module: lsq_mem_ctrl

Interface
REQ-001 SHALL have these ports (name direction width meaning), clock and reset first:
  clk  in  1  clock
  rst  in  1  reset: synchronous, active-high
  flush  in  1  pipeline flush
  lsq_read_enable  out  1  pop request to the load/store queue
  lsq_read_resp  in  1  queue entry valid; registered one cycle after pop
  lsq_opcode  in  7  op_b_load / op_b_store
  lsq_funct3  in  3  access size and sign
  lsq_rs1_v  in  32  base register value
  lsq_rs2_v  in  32  store data value
  lsq_imm  in  32  offset
  lsq_phys_rd  in  $clog2(NUM_REGS)  destination physical register
  lsq_rob_index  in  $clog2(ROB_SIZE)  ROB tag
  dmem_addr  out  32  word-aligned address
  dmem_rmask  out  4  read byte mask
  dmem_wmask  out  4  write byte mask
  dmem_wdata  out  32  lane-shifted store data
  dmem_rdata  in  32  read data
  dmem_resp  in  1  memory response, one cycle
  cdb_valid  out  1  completion broadcast
  cdb_regf_we  out  1  register-file write (loads only)
  cdb_phys_rd  out  $clog2(NUM_REGS)  broadcast register
  cdb_rob_index  out  $clog2(ROB_SIZE)  broadcast ROB tag
  cdb_data  out  32  load result
  cdb_exc  out  1  misaligned-access exception
  busy  out  1  state != IDLE

Function
REQ-002 SHALL implement FSM states IDLE, POLL, REQ, DRAIN, WB.
REQ-003 IDLE: SHALL drive lsq_read_enable=1 for one cycle, then go to POLL.
REQ-004 POLL: lsq_read_enable=0. If lsq_read_resp=1, SHALL capture all lsq_* fields and go to REQ. Otherwise SHALL return to IDLE. At most one entry pops per two cycles.
REQ-005 Effective address SHALL be ea = lsq_rs1_v + lsq_imm, modulo 2^32. dmem_addr SHALL be {ea[31:2],2'b00}.
REQ-006 Masks by funct3: byte (000/100) = 4'b0001<<ea[1:0]; half (001/101) = 4'b0011<<ea[1:0]; word (010) = 4'b1111. Loads drive rmask only; stores drive wmask only.
REQ-007 dmem_wdata SHALL be lsq_rs2_v << (8*ea[1:0]).
REQ-008 REQ: masks and address SHALL be held stable until dmem_resp=1, then go to WB. Outside REQ and DRAIN, masks SHALL be 0.
REQ-009 WB: SHALL assert cdb_valid for exactly one cycle, then go to IDLE.
  - Load: cdb_regf_we=1; cdb_data = (dmem_rdata >> 8*ea[1:0]), sign-extended for 000/001 and zero-extended for 100/101.
  - Store: cdb_regf_we=0, cdb_data=0.
REQ-010 flush in IDLE, POLL or WB SHALL force IDLE next cycle. A captured entry is dropped and cdb_valid=0 in that cycle.
REQ-011 flush in REQ SHALL go to DRAIN. DRAIN holds the request until dmem_resp, discards the response, then goes to IDLE with no cdb_valid.
REQ-012 flush in the same cycle as lsq_read_resp SHALL discard the entry.
REQ-013 Store ordering is enforced by the queue (head-of-ROB gating). This block SHALL NOT reorder accesses.

Reset
REQ-014 rst SHALL take priority over flush.
REQ-015 On rst: state=IDLE, captured fields=0, and every output=0, including dmem_* masks and cdb_*.
REQ-016 rst during REQ SHALL abandon the request without draining. Memory tolerates this.

Configuration
REQ-017 Macro LSQ_MISALIGN_TRAP_EN, when defined: half with ea[0]=1, or word with ea[1:0]!=0, SHALL skip REQ and go POLL->WB with cdb_exc=1, cdb_regf_we=0, masks=0.
REQ-018 When undefined: cdb_exc SHALL be tied 0. The offending low ea bits SHALL be forced to 0 for mask, shift and extract (half clears ea[0], word clears ea[1:0]).

Structure
REQ-019 An lsq_mem_state_t enum and funct3 size encodings SHALL live in rv32i_types. NUM_REGS, ROB_SIZE and op_b_load/op_b_store SHALL come from the same package.
REQ-020 The load extract/extend and store-lane logic SHALL be one combinational sub-module, lsq_lane_align.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - lw: rs1=0x1000, imm=4, rdata=0xDEADBEEF -> dmem_addr=0x1004, rmask=1111, cdb_data=0xDEADBEEF, regf_we=1.
  - lb: ea=0x2003, rdata=0x80112233 -> rmask=1000, cdb_data=0xFFFFFF80. Same as lbu -> cdb_data=0x00000080.
  - sh: ea=0x3002, rs2=0x0000ABCD -> wmask=1100, wdata=0xABCD0000, cdb_valid=1, regf_we=0.
  - dmem_resp delayed 5 cycles with flush in REQ -> DRAIN until resp, then IDLE, cdb_valid never asserted.
  - lw at ea=0x4001 -> with LSQ_MISALIGN_TRAP_EN: no dmem access, cdb_exc=1. Without: dmem_addr=0x4000, rmask=1111.
  - lsq_read_resp=0 in POLL (store blocked) -> back to IDLE, lsq_read_enable re-pulses every 2 cycles, no dmem activity.

Source files
------------

// File: rtl/lsq_mem_ctrl_pkg.sv
// Shared RV32I types for the load/store memory controller: register-file and
// ROB sizing, load/store opcodes, funct3 access-size encodings, the controller
// state enum and small size/alignment helpers.
package rv32i_types;

    localparam int unsigned NUM_REGS = 64;
    localparam int unsigned ROB_SIZE = 16;
    localparam int unsigned PHYS_W   = $clog2(NUM_REGS);
    localparam int unsigned ROB_W    = $clog2(ROB_SIZE);

    localparam logic [6:0] op_b_load  = 7'b0000011;
    localparam logic [6:0] op_b_store = 7'b0100011;

    // funct3 access size; bit 2 set means zero-extend on loads
    localparam logic [2:0] Funct3Byte  = 3'b000;
    localparam logic [2:0] Funct3Half  = 3'b001;
    localparam logic [2:0] Funct3Word  = 3'b010;
    localparam logic [2:0] Funct3ByteU = 3'b100;
    localparam logic [2:0] Funct3HalfU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StPoll,
        StReq,
        StDrain,
        StWb
    } lsq_mem_state_t;

    // Byte offset actually used for lanes: halves drop bit 0, words drop both bits.
    function automatic logic [1:0] align_offset(input logic [2:0] funct3,
                                                input logic [1:0] ea_lo);
        case (funct3)
            Funct3Half, Funct3HalfU: return {ea_lo[1], 1'b0};
            Funct3Word:              return 2'b00;
            default:                 return ea_lo;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] ea_lo);
        case (funct3)
            Funct3Half, Funct3HalfU: return ea_lo[0];
            Funct3Word:              return |ea_lo;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsq_lane_align.sv
// Combinational byte-lane steering: byte mask and store-data shift for the
// outgoing access, extract and sign/zero extension for the returning load.
module lsq_lane_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  byte_mask,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [1:0]  off;
    logic [31:0] shifted;

    // Mask, store lanes and load extract from the size-aligned offset
    always_comb begin
        off         = align_offset(funct3, ea_lo);
        store_lanes = store_data << {off, 3'b000};
        shifted     = load_raw >> {off, 3'b000};
        byte_mask   = 4'b0000;
        load_data   = shifted;
        case (funct3)
            Funct3Byte: begin
                byte_mask = 4'b0001 << off;
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            Funct3ByteU: begin
                byte_mask = 4'b0001 << off;
                load_data = {24'b0, shifted[7:0]};
            end
            Funct3Half: begin
                byte_mask = 4'b0011 << off;
                load_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            Funct3HalfU: begin
                byte_mask = 4'b0011 << off;
                load_data = {16'b0, shifted[15:0]};
            end
            Funct3Word: begin
                byte_mask = 4'b1111;
                load_data = shifted;
            end
            default: begin
                byte_mask = 4'b0000;
                load_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsq_mem_ctrl.sv
// Load/store memory controller: pops one LSQ entry at a time, issues a single
// data-memory access, and broadcasts completion on the CDB. Flushes drop the
// entry; a flush during an outstanding access drains the response first.
// Optional build macro LSQ_MISALIGN_TRAP_EN: misaligned half/word accesses
// skip memory and complete with cdb_exc=1 instead of being force-aligned.
module lsq_mem_ctrl
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              lsq_read_enable,
    input  logic              lsq_read_resp,
    input  logic [6:0]        lsq_opcode,
    input  logic [2:0]        lsq_funct3,
    input  logic [31:0]       lsq_rs1_v,
    input  logic [31:0]       lsq_rs2_v,
    input  logic [31:0]       lsq_imm,
    input  logic [PHYS_W-1:0] lsq_phys_rd,
    input  logic [ROB_W-1:0]  lsq_rob_index,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              cdb_valid,
    output logic              cdb_regf_we,
    output logic [PHYS_W-1:0] cdb_phys_rd,
    output logic [ROB_W-1:0]  cdb_rob_index,
    output logic [31:0]       cdb_data,
    output logic              cdb_exc,
    output logic              busy
);

    lsq_mem_state_t    state_q, state_d;
    logic              capture;
    logic              rdata_we;
    logic              trap_in;
    logic [31:0]       ea_in;

    logic              is_load_q;
    logic [2:0]        funct3_q;
    logic [31:0]       ea_q;
    logic [31:0]       rs2_q;
    logic [PHYS_W-1:0] phys_rd_q;
    logic [ROB_W-1:0]  rob_q;
    logic [31:0]       rdata_q;
    logic              exc_q;

    logic [3:0]        lane_mask;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_load;

    assign ea_in = lsq_rs1_v + lsq_imm;

`ifdef LSQ_MISALIGN_TRAP_EN
    assign trap_in = is_misaligned(lsq_funct3, ea_in[1:0]);
`else
    assign trap_in = 1'b0;
`endif

    lsq_lane_align u_lane_align (
        .funct3      (funct3_q),
        .ea_lo       (ea_q[1:0]),
        .store_data  (rs2_q),
        .load_raw    (rdata_q),
        .byte_mask   (lane_mask),
        .store_lanes (lane_wdata),
        .load_data   (lane_load)
    );

    // Next-state: one pop per IDLE/POLL pair, flushes steer back to IDLE or DRAIN
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        rdata_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!flush) state_d = StPoll;
            end
            StPoll: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (lsq_read_resp) begin
                    capture = 1'b1;
                    state_d = trap_in ? StWb : StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            StReq: begin
                if (flush) begin
                    // A response landing with the flush is already drained
                    state_d = dmem_resp ? StIdle : StDrain;
                end else if (dmem_resp) begin
                    rdata_we = 1'b1;
                    state_d  = StWb;
                end
            end
            StDrain: begin
                if (dmem_resp) state_d = StIdle;
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and captured-entry registers; rst wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            is_load_q <= 1'b0;
            funct3_q  <= 3'b0;
            ea_q      <= 32'b0;
            rs2_q     <= 32'b0;
            phys_rd_q <= '0;
            rob_q     <= '0;
            rdata_q   <= 32'b0;
            exc_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                is_load_q <= (lsq_opcode == op_b_load);
                funct3_q  <= lsq_funct3;
                ea_q      <= ea_in;
                rs2_q     <= lsq_rs2_v;
                phys_rd_q <= lsq_phys_rd;
                rob_q     <= lsq_rob_index;
                exc_q     <= trap_in;
            end
            if (rdata_we) rdata_q <= dmem_rdata;
        end
    end

    // Outputs decoded from state; all forced to 0 while rst is asserted
    always_comb begin
        lsq_read_enable = 1'b0;
        dmem_addr       = 32'b0;
        dmem_rmask      = 4'b0;
        dmem_wmask      = 4'b0;
        dmem_wdata      = 32'b0;
        cdb_valid       = 1'b0;
        cdb_regf_we     = 1'b0;
        cdb_phys_rd     = '0;
        cdb_rob_index   = '0;
        cdb_data        = 32'b0;
        cdb_exc         = 1'b0;
        busy            = 1'b0;
        if (!rst) begin
            busy = (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    // No pop while flushing: the entry would have nowhere to go
                    lsq_read_enable = !flush;
                end
                StReq, StDrain: begin
                    dmem_addr = {ea_q[31:2], 2'b00};
                    if (is_load_q) begin
                        dmem_rmask = lane_mask;
                    end else begin
                        dmem_wmask = lane_mask;
                        dmem_wdata = lane_wdata;
                    end
                end
                StWb: begin
                    if (!flush) begin
                        cdb_valid     = 1'b1;
                        cdb_phys_rd   = phys_rd_q;
                        cdb_rob_index = rob_q;
`ifdef LSQ_MISALIGN_TRAP_EN
                        cdb_exc       = exc_q;
`endif
                        if (is_load_q && !exc_q) begin
                            cdb_regf_we = 1'b1;
                            cdb_data    = lane_load;
                        end
                    end
                end
                default: begin
                    busy = busy;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsq_mem_ctrl.sv
// Self-checking bench for lsq_mem_ctrl: directed scenarios followed by
// randomized loads/stores against a byte-arithmetic reference model.
module tb_lsq_mem_ctrl;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic              lsq_read_enable, lsq_read_resp;
    logic [6:0]        lsq_opcode;
    logic [2:0]        lsq_funct3;
    logic [31:0]       lsq_rs1_v, lsq_rs2_v, lsq_imm;
    logic [PHYS_W-1:0] lsq_phys_rd;
    logic [ROB_W-1:0]  lsq_rob_index;
    logic [31:0]       dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]        dmem_rmask, dmem_wmask;
    logic              dmem_resp;
    logic              cdb_valid, cdb_regf_we, cdb_exc, busy;
    logic [PHYS_W-1:0] cdb_phys_rd;
    logic [ROB_W-1:0]  cdb_rob_index;
    logic [31:0]       cdb_data;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lsq_mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .lsq_read_enable (lsq_read_enable),
        .lsq_read_resp   (lsq_read_resp),
        .lsq_opcode      (lsq_opcode),
        .lsq_funct3      (lsq_funct3),
        .lsq_rs1_v       (lsq_rs1_v),
        .lsq_rs2_v       (lsq_rs2_v),
        .lsq_imm         (lsq_imm),
        .lsq_phys_rd     (lsq_phys_rd),
        .lsq_rob_index   (lsq_rob_index),
        .dmem_addr       (dmem_addr),
        .dmem_rmask      (dmem_rmask),
        .dmem_wmask      (dmem_wmask),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_resp       (dmem_resp),
        .cdb_valid       (cdb_valid),
        .cdb_regf_we     (cdb_regf_we),
        .cdb_phys_rd     (cdb_phys_rd),
        .cdb_rob_index   (cdb_rob_index),
        .cdb_data        (cdb_data),
        .cdb_exc         (cdb_exc),
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop();
        int n = 0;
        while (lsq_read_enable !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("pop_pulse", {31'b0, lsq_read_enable}, 32'd1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rmask"}, {28'b0, dmem_rmask}, 32'd0);
        chk({tag, "_wmask"}, {28'b0, dmem_wmask}, 32'd0);
        chk({tag, "_cdbv"}, {31'b0, cdb_valid}, 32'd0);
    endtask

    // Reference: access size in bytes from funct3
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b010) return 4;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 1;
    endfunction

    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] rdata, input int delay, input bit flush_req,
                         input bit flush_wb);
        logic [31:0]       ea, exp_addr, exp_wdata, exp_load;
        logic [3:0]        exp_mask;
        logic [PHYS_W-1:0] rd;
        logic [ROB_W-1:0]  rob;
        longint unsigned   v, one;
        int                sz, off;
        bit                is_ld, trap;

        rd       = PHYS_W'($urandom);
        rob      = ROB_W'($urandom);
        is_ld    = (op == op_b_load);
        ea       = rs1 + imm;
        sz       = size_of(f3);
        off      = int'(ea % 4);
        trap     = 1'b0;
`ifdef LSQ_MISALIGN_TRAP_EN
        trap     = (off % sz) != 0;
`endif
        off       = off - (off % sz);
        exp_addr  = ea - (ea % 4);
        exp_mask  = 4'(((1 << sz) - 1) << off);
        exp_wdata = rs2 << (8 * off);
        one       = 1;
        v         = longint'(rdata >> (8 * off)) % (one << (8 * sz));
        if (sz < 4 && f3[2] == 1'b0 && v >= (one << (8 * sz - 1))) v = v - (one << (8 * sz));
        exp_load  = v[31:0];

        wait_pop();
        tick();
        chk("poll_ren", {31'b0, lsq_read_enable}, 32'd0);
        chk_quiet("poll");
        lsq_read_resp = 1'b1;
        lsq_opcode    = op;
        lsq_funct3    = f3;
        lsq_rs1_v     = rs1;
        lsq_rs2_v     = rs2;
        lsq_imm       = imm;
        lsq_phys_rd   = rd;
        lsq_rob_index = rob;
        tick();
        lsq_read_resp = 1'b0;
        lsq_rs1_v     = $urandom;
        lsq_rs2_v     = $urandom;
        lsq_imm       = $urandom;

        if (trap) begin
            chk("trap_cdbv", {31'b0, cdb_valid}, 32'd1);
            chk("trap_exc", {31'b0, cdb_exc}, 32'd1);
            chk("trap_we", {31'b0, cdb_regf_we}, 32'd0);
            chk("trap_rmask", {28'b0, dmem_rmask}, 32'd0);
            chk("trap_wmask", {28'b0, dmem_wmask}, 32'd0);
            tick();
            chk("trap_idle", {31'b0, busy}, 32'd0);
            return;
        end

        for (int c = 0; c <= delay; c++) begin
            chk("req_addr", dmem_addr, exp_addr);
            chk("req_rmask", {28'b0, dmem_rmask}, is_ld ? {28'b0, exp_mask} : 32'd0);
            chk("req_wmask", {28'b0, dmem_wmask}, is_ld ? 32'd0 : {28'b0, exp_mask});
            if (!is_ld) chk("req_wdata", dmem_wdata, exp_wdata);
            chk("req_cdbv", {31'b0, cdb_valid}, 32'd0);
            chk("req_busy", {31'b0, busy}, 32'd1);
            if (c == 0 && flush_req) flush = 1'b1;
            if (c == delay) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
            flush      = 1'b0;
            dmem_resp  = 1'b0;
            dmem_rdata = $urandom;
        end

        if (flush_req) begin
            chk("drain_cdbv", {31'b0, cdb_valid}, 32'd0);
            chk("drain_idle", {31'b0, busy}, 32'd0);
            chk("drain_rmask", {28'b0, dmem_rmask}, 32'd0);
        end else if (flush_wb) begin
            flush = 1'b1;
            #1;
            chk("wbflush_cdbv", {31'b0, cdb_valid}, 32'd0);
            tick();
            flush = 1'b0;
            chk("wbflush_idle", {31'b0, busy}, 32'd0);
        end else begin
            chk("wb_cdbv", {31'b0, cdb_valid}, 32'd1);
            chk("wb_we", {31'b0, cdb_regf_we}, {31'b0, is_ld});
            chk("wb_data", cdb_data, is_ld ? exp_load : 32'd0);
            chk("wb_rd", {26'b0, cdb_phys_rd}, {26'b0, rd});
            chk("wb_rob", {28'b0, cdb_rob_index}, {28'b0, rob});
            chk("wb_exc", {31'b0, cdb_exc}, 32'd0);
            chk("wb_rmask", {28'b0, dmem_rmask}, 32'd0);
            tick();
            chk("wb_once", {31'b0, cdb_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};

        rst = 1'b1; flush = 1'b0; lsq_read_resp = 1'b0; lsq_opcode = 7'b0;
        lsq_funct3 = 3'b0; lsq_rs1_v = 32'b0; lsq_rs2_v = 32'b0; lsq_imm = 32'b0;
        lsq_phys_rd = '0; lsq_rob_index = '0; dmem_rdata = 32'b0; dmem_resp = 1'b0;

        // Reset: every output low while rst is held
        tick();
        tick();
        chk("rst_ren", {31'b0, lsq_read_enable}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_data", cdb_data, 32'd0);
        chk("rst_we", {31'b0, cdb_regf_we}, 32'd0);
        chk("rst_exc", {31'b0, cdb_exc}, 32'd0);
        chk_quiet("rst");
        rst = 1'b0;
        #1;
        chk("rel_ren", {31'b0, lsq_read_enable}, 32'd1);

        // Directed: lw, lb, lbu, sh
        do_op(op_b_load, 3'b010, 32'h1000, 32'h0, 32'd4, 32'hDEADBEEF, 2, 1'b0, 1'b0);
        do_op(op_b_load, 3'b000, 32'h2000, 32'h0, 32'd3, 32'h80112233, 1, 1'b0, 1'b0);
        do_op(op_b_load, 3'b100, 32'h2000, 32'h0, 32'd3, 32'h80112233, 0, 1'b0, 1'b0);
        do_op(op_b_store, 3'b001, 32'h3000, 32'h0000ABCD, 32'd2, 32'h0, 1, 1'b0, 1'b0);
        // Flush in REQ with a slow memory: drain, no broadcast
        do_op(op_b_load, 3'b010, 32'h5000, 32'h0, 32'd8, 32'h12345678, 5, 1'b1, 1'b0);
        // Misaligned word load
        do_op(op_b_load, 3'b010, 32'h4000, 32'h0, 32'd1, 32'hCAFEF00D, 1, 1'b0, 1'b0);

        // Empty queue: enable re-pulses every other cycle with no memory traffic
        for (int i = 0; i < 3; i++) begin
            wait_pop();
            chk("blk_busy0", {31'b0, busy}, 32'd0);
            tick();
            chk("blk_ren", {31'b0, lsq_read_enable}, 32'd0);
            chk("blk_busy1", {31'b0, busy}, 32'd1);
            chk_quiet("blk");
            tick();
        end

        // Flush together with the popped entry: entry discarded
        wait_pop();
        tick();
        lsq_read_resp = 1'b1; lsq_opcode = op_b_store; lsq_funct3 = 3'b010;
        flush = 1'b1;
        tick();
        lsq_read_resp = 1'b0; flush = 1'b0;
        chk("pollflush_idle", {31'b0, busy}, 32'd0);
        chk_quiet("pollflush");

        // rst during REQ abandons the access immediately
        wait_pop();
        tick();
        lsq_read_resp = 1'b1; lsq_opcode = op_b_load; lsq_funct3 = 3'b010;
        lsq_rs1_v = 32'h6000; lsq_imm = 32'h0;
        tick();
        lsq_read_resp = 1'b0;
        chk("rstreq_rmask_on", {28'b0, dmem_rmask}, 32'hF);
        rst = 1'b1;
        #1;
        chk("rstreq_rmask", {28'b0, dmem_rmask}, 32'd0);
        chk("rstreq_addr", dmem_addr, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstreq_idle", {31'b0, busy}, 32'd0);
        chk("rstreq_ren", {31'b0, lsq_read_enable}, 32'd1);

        // Randomized loads and stores
        for (int i = 0; i < 40; i++) begin
            bit ld, fr, fw;
            ld = 1'($urandom_range(0, 1));
            fr = ($urandom_range(0, 7) == 0);
            fw = !fr && ($urandom_range(0, 9) == 0);
            do_op(ld ? op_b_load : op_b_store,
                  ld ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)],
                  $urandom, $urandom, 32'($urandom_range(0, 4095)), $urandom,
                  int'($urandom_range(0, 4)), fr, fw);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
